// File: rtl/synth_pkg.sv
// Shared types and default widths for the wavetable oscillator slice.
package synth_pkg;

    localparam int unsigned DefAddrWidth  = 12;
    localparam int unsigned DefWidth      = 16;
    localparam int unsigned DefPhaseWidth = 32;
    localparam int unsigned DefFracWidth  = 8;

    typedef enum logic [2:0] {
        StIdle,
        StRd0,
        StRd1,
        StRd2,
        StCalc,
        StOut
    } osc_state_t;

    typedef logic signed [DefWidth-1:0] sample_t;

endpackage

// File: rtl/wavetable_osc_if.sv
// Oscillator control, ROM and sample-output signals bundled as one interface.
interface wavetable_osc_if
    import synth_pkg::*;
#(
    parameter int unsigned ADDRWIDTH  = DefAddrWidth,
    parameter int unsigned WIDTH      = DefWidth,
    parameter int unsigned PHASEWIDTH = DefPhaseWidth
) ();

    logic                  sample_tick;
    logic [PHASEWIDTH-1:0] tune_word;
    logic                  phase_rst;
    logic [ADDRWIDTH-1:0]  rom_addr;
    logic [WIDTH-1:0]      rom_data;
    logic [WIDTH-1:0]      sample_out;
    logic                  sample_valid;
    logic                  busy;
    logic                  overrun;

    // Oscillator side.
    modport slave (
        input  sample_tick, tune_word, phase_rst, rom_data,
        output rom_addr, sample_out, sample_valid, busy, overrun
    );

    // Controller / ROM / sink side.
    modport master (
        output sample_tick, tune_word, phase_rst, rom_data,
        input  rom_addr, sample_out, sample_valid, busy, overrun
    );

endinterface

// File: rtl/lerp_unit.sv
// Linear interpolator: registered (s1 - s0) * frac, then s0 + floor(product / 2**FRACWIDTH).
module lerp_unit #(
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned FRACWIDTH = 8
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 en,
    input  logic [WIDTH-1:0]     s0,
    input  logic [WIDTH-1:0]     s1,
    input  logic [FRACWIDTH-1:0] frac,
    output logic [WIDTH-1:0]     result
);

    localparam int unsigned ProdW = WIDTH + FRACWIDTH + 2;

    logic signed [WIDTH:0]     diff;
    logic signed [FRACWIDTH:0] frac_s;
    logic signed [ProdW-1:0]   prod_d;
    logic signed [ProdW-1:0]   prod_q;

    // Difference needs one extra bit; frac is zero-extended so it stays non-negative.
    always_comb begin
        diff   = $signed({s1[WIDTH-1], s1}) - $signed({s0[WIDTH-1], s0});
        frac_s = $signed({1'b0, frac});
        prod_d = ProdW'(diff) * ProdW'(frac_s);
    end

    // Product register, loaded only in the CALC cycle.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            prod_q <= '0;
        end else if (en) begin
            prod_q <= prod_d;
        end
    end

    // Arithmetic shift floors; the sum lies between s0 and s1 so truncation is exact.
    always_comb begin
        result = WIDTH'(ProdW'($signed(s0)) + (prod_q >>> FRACWIDTH));
    end

endmodule

// File: rtl/wavetable_osc.sv
// NCO: phase accumulator plus ROM read sequencer feeding a linear interpolator.
module wavetable_osc
    import synth_pkg::*;
#(
    parameter int unsigned ADDRWIDTH  = DefAddrWidth,
    parameter int unsigned WIDTH      = DefWidth,
    parameter int unsigned PHASEWIDTH = DefPhaseWidth,
    parameter int unsigned FRACWIDTH  = DefFracWidth
) (
    input  logic          Clk,
    input  logic          Reset,
    wavetable_osc_if.slave bus
);

    localparam int unsigned IdxLsb = PHASEWIDTH - ADDRWIDTH;

    osc_state_t            state_q, state_d;
    logic [PHASEWIDTH-1:0] phase_q, phase_d, phase_base;
    logic [ADDRWIDTH-1:0]  idx_q, idx_d;
    logic [ADDRWIDTH-1:0]  rom_addr_q, rom_addr_d;
    logic [FRACWIDTH-1:0]  frac_q, frac_d;
    logic [WIDTH-1:0]      s0_q, s0_d, s1_q, s1_d;
    logic [WIDTH-1:0]      hold_q, hold_d;
    logic                  lerp_en;
    logic [WIDTH-1:0]      lerp_result;

    // Next-state: sequencer, phase accumulator and sample capture.
    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        idx_d      = idx_q;
        frac_d     = frac_q;
        rom_addr_d = rom_addr_q;
        s0_d       = s0_q;
        s1_d       = s1_q;
        hold_d     = hold_q;
        lerp_en    = 1'b0;
        // A phase_rst coinciding with an accepted tick makes that sample use phase 0.
        phase_base = bus.phase_rst ? '0 : phase_q;
        if (bus.phase_rst) begin
            phase_d = '0;
        end
        case (state_q)
            StIdle: begin
                if (bus.sample_tick) begin
                    idx_d      = phase_base[PHASEWIDTH-1 -: ADDRWIDTH];
                    frac_d     = phase_base[IdxLsb-1 -: FRACWIDTH];
                    rom_addr_d = phase_base[PHASEWIDTH-1 -: ADDRWIDTH];
                    phase_d    = phase_base + bus.tune_word;
                    state_d    = StRd0;
                end
            end
            StRd0: begin
                rom_addr_d = idx_q + ADDRWIDTH'(1);
                state_d    = StRd1;
            end
            StRd1: begin
                s0_d    = bus.rom_data;
                state_d = StRd2;
            end
            StRd2: begin
                s1_d    = bus.rom_data;
                state_d = StCalc;
            end
            StCalc: begin
                lerp_en = 1'b1;
                state_d = StOut;
            end
            StOut: begin
                hold_d  = lerp_result;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_q    <= StIdle;
            phase_q    <= '0;
            idx_q      <= '0;
            frac_q     <= '0;
            rom_addr_q <= '0;
            s0_q       <= '0;
            s1_q       <= '0;
            hold_q     <= '0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            idx_q      <= idx_d;
            frac_q     <= frac_d;
            rom_addr_q <= rom_addr_d;
            s0_q       <= s0_d;
            s1_q       <= s1_d;
            hold_q     <= hold_d;
        end
    end

    lerp_unit #(
        .WIDTH    (WIDTH),
        .FRACWIDTH(FRACWIDTH)
    ) u_lerp (
        .Clk   (Clk),
        .Reset (Reset),
        .en    (lerp_en),
        .s0    (s0_q),
        .s1    (s1_q),
        .frac  (frac_q),
        .result(lerp_result)
    );

    // Outputs; the fresh result is shown during OUT, then held.
    always_comb begin
        bus.rom_addr     = rom_addr_q;
        bus.sample_valid = (state_q == StOut);
        bus.sample_out   = (state_q == StOut) ? lerp_result : hold_q;
        bus.busy         = (state_q != StIdle);
        bus.overrun      = bus.sample_tick && (state_q != StIdle);
    end

endmodule

// File: tb/tb_wavetable_osc.sv
// Scoreboard bench for wavetable_osc with a registered ROM model, mem[i] = i*16.
module tb_wavetable_osc;
    import synth_pkg::*;

    logic Clk = 1'b0;
    logic Reset = 1'b0;
    always #5 Clk = ~Clk;

    wavetable_osc_if #(.ADDRWIDTH(12), .WIDTH(16), .PHASEWIDTH(32)) bus ();

    wavetable_osc #(
        .ADDRWIDTH (12),
        .WIDTH     (16),
        .PHASEWIDTH(32),
        .FRACWIDTH (8)
    ) dut (
        .Clk  (Clk),
        .Reset(Reset),
        .bus  (bus)
    );

    logic [15:0] mem [4096];

    // Registered ROM: data valid one cycle after the address.
    always @(posedge Clk) bus.rom_data <= mem[bus.rom_addr];

    int cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    typedef struct {
        sample_t val;
        int      cyc;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Monitor: every sample_valid must match the oldest expected sample and its cycle.
    always @(negedge Clk) begin
        exp_t e;
        if (Reset === 1'b1 && bus.sample_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid: got sample 0x%0h expected no sample (cycle %0d)",
                         bus.sample_out, cyc);
            end else begin
                e = exp_q.pop_front();
                check("sample_value", {16'h0, bus.sample_out}, {16'h0, e.val});
                check("sample_latency", cyc, e.cyc);
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    // Issue one tick; returns one ns into cycle T+1 (or T+2 when addresses are checked).
    task automatic tick(input logic [31:0] tw, input logic [15:0] expv, input bit push,
                        input bit chk_addr, input int unsigned idx);
        @(posedge Clk);
        #1;
        bus.tune_word   = tw;
        bus.sample_tick = 1'b1;
        if (push) exp_q.push_back('{val: expv, cyc: cyc + 5});
        @(posedge Clk);
        #1;
        bus.sample_tick = 1'b0;
        if (chk_addr) begin
            @(negedge Clk);
            check("rom_addr_idx", {20'h0, bus.rom_addr}, idx);
            @(negedge Clk);
            check("rom_addr_idx1", {20'h0, bus.rom_addr}, (idx + 1) % 4096);
        end
    endtask

    task automatic do_reset();
        @(posedge Clk);
        #1;
        Reset = 1'b0;
        repeat (3) @(posedge Clk);
        #1;
        Reset = 1'b1;
        @(negedge Clk);
        check("rst_rom_addr", {20'h0, bus.rom_addr}, 32'h0);
        check("rst_sample_out", {16'h0, bus.sample_out}, 32'h0);
        check("rst_sample_valid", {31'h0, bus.sample_valid}, 32'h0);
        check("rst_busy", {31'h0, bus.busy}, 32'h0);
        check("rst_overrun", {31'h0, bus.overrun}, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 16'(i * 16);
        bus.sample_tick = 1'b0;
        bus.tune_word   = '0;
        bus.phase_rst   = 1'b0;

        do_reset();

        // Integer step: one table entry per tick.
        for (int k = 0; k < 4; k++) begin
            tick(32'h0010_0000, 16'(k * 16), 1'b1, 1'b1, k);
            idle(5);
        end

        // Half-step interpolation.
        do_reset();
        tick(32'h0008_0000, 16'd0, 1'b1, 1'b0, 0);
        idle(6);
        tick(32'h0008_0000, 16'd8, 1'b1, 1'b0, 0);
        idle(6);
        tick(32'h0008_0000, 16'd16, 1'b1, 1'b0, 0);
        idle(6);

        // Table wrap: 4095 -> 0 interpolates -16 toward 0.
        do_reset();
        tick(32'h0010_0000, 16'd0, 1'b1, 1'b0, 0);
        idle(6);
        @(posedge Clk);
        #1;
        bus.phase_rst = 1'b1;
        @(posedge Clk);
        #1;
        bus.phase_rst = 1'b0;
        tick(32'hFFF8_0000, 16'd0, 1'b1, 1'b1, 0);
        idle(6);
        tick(32'hFFF8_0000, 16'hFFF8, 1'b1, 1'b1, 4095);
        idle(6);

        // Overrun: second tick at T+2 is dropped and does not move the phase.
        do_reset();
        tick(32'h0010_0000, 16'd0, 1'b1, 1'b0, 0);
        @(negedge Clk);
        check("no_overrun_idle_tick", {31'h0, bus.overrun}, 32'h0);
        @(posedge Clk);
        #1;
        bus.sample_tick = 1'b1;
        @(negedge Clk);
        check("overrun_pulse", {31'h0, bus.overrun}, 32'h1);
        check("busy_in_flight", {31'h0, bus.busy}, 32'h1);
        @(posedge Clk);
        #1;
        bus.sample_tick = 1'b0;
        @(negedge Clk);
        check("overrun_clears", {31'h0, bus.overrun}, 32'h0);
        idle(6);
        tick(32'h0010_0000, 16'd16, 1'b1, 1'b0, 0);
        idle(6);

        // Reset at T+3 aborts the sample.
        do_reset();
        tick(32'h0010_0000, 16'd0, 1'b0, 1'b0, 0);
        @(posedge Clk);
        #1;
        @(posedge Clk);
        #1;
        Reset = 1'b0;
        @(posedge Clk);
        #1;
        @(negedge Clk);
        check("abort_busy", {31'h0, bus.busy}, 32'h0);
        @(posedge Clk);
        #1;
        Reset = 1'b1;
        idle(6);
        tick(32'h0010_0000, 16'd0, 1'b1, 1'b0, 0);
        idle(6);

        // phase_rst during RD1: in-flight sample keeps its index, next uses phase 0.
        do_reset();
        tick(32'h0010_0000, 16'd0, 1'b1, 1'b0, 0);
        idle(6);
        tick(32'h0010_0000, 16'd16, 1'b1, 1'b0, 0);
        @(posedge Clk);
        #1;
        bus.phase_rst = 1'b1;
        @(posedge Clk);
        #1;
        bus.phase_rst = 1'b0;
        idle(6);
        tick(32'h0010_0000, 16'd0, 1'b1, 1'b0, 0);
        idle(6);

        // tune_word = 0 repeats the same interpolated sample.
        do_reset();
        tick(32'h0028_0000, 16'd0, 1'b1, 1'b0, 0);
        idle(6);
        tick(32'h0000_0000, 16'd40, 1'b1, 1'b0, 0);
        idle(6);
        tick(32'h0000_0000, 16'd40, 1'b1, 1'b0, 0);
        idle(6);

        // Drain the scoreboard with a bounded wait.
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge Clk);
        while (exp_q.size() != 0) begin
            exp_t e;
            e = exp_q.pop_front();
            checks++;
            errors++;
            $display("FAIL missing_sample: got none expected 0x%0h at cycle %0d", e.val, e.cyc);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/wavetable_osc.md
Name: wavetable_osc

Overview:
- Numerically controlled oscillator: phase accumulator plus read sequencer that sits directly upstream of the wavetable ROM.
- Drives the ROM address, captures the ROM's registered data, and linearly interpolates between adjacent table entries.
- Emits one signed sample per accepted sample tick to the downstream mixer/DAC path.

Parameters:
- ADDRWIDTH, 12, ROM address width; table holds 2**ADDRWIDTH entries.
- WIDTH, 16, sample width; two's-complement signed.
- PHASEWIDTH, 32, phase accumulator and tuning word width.
- FRACWIDTH, 8, interpolation fraction bits, taken directly below the index bits.

Ports:
- Clk  in  1  system clock
- Reset  in  1  synchronous, active-low reset
- sample_tick  in  1  one-cycle request for a new sample
- tune_word  in  PHASEWIDTH  phase increment per sample, unsigned
- phase_rst  in  1  one-cycle pulse; clears phase (note-on sync)
- rom_addr  out  ADDRWIDTH  address to ROM, registered
- rom_data  in  WIDTH  ROM output; valid one cycle after rom_addr
- sample_out  out  WIDTH  interpolated sample, signed, held between updates
- sample_valid  out  1  one-cycle pulse when sample_out updates
- busy  out  1  high while a sample is in progress
- overrun  out  1  one-cycle pulse when a tick is dropped

Behaviour:
- Reset: Reset is synchronous and active-low.
  - On Reset==0 at a rising edge: phase, rom_addr, sample_out, sample_valid, busy and overrun all go to 0; state goes to IDLE.
  - Reset asserted mid-sequence aborts the sequence; no sample_valid is issued.
- Phase fields:
  - idx = phase[PHASEWIDTH-1 -: ADDRWIDTH].
  - frac = the next FRACWIDTH bits below idx. Remaining low bits only accumulate.
- States: IDLE -> RD0 -> RD1 -> RD2 -> CALC -> OUT -> IDLE.
  - busy = (state != IDLE).
- Tick accepted in IDLE (cycle T):
  - Latch idx and frac of the current phase.
  - phase <= phase + tune_word, wrapping mod 2**PHASEWIDTH.
  - tune_word is sampled only at T.
- RD0 (T+1): rom_addr = idx.
- RD1 (T+2):
  - Capture s0 = rom_data at the end of the cycle.
  - rom_addr = idx+1 mod 2**ADDRWIDTH, so 4095 wraps to 0.
- RD2 (T+3): capture s1 = rom_data.
- CALC (T+4): register diff*frac.
  - diff = s1 - s0 computed at WIDTH+1 bits, signed.
  - frac treated as unsigned (zero-extended).
- OUT (T+5):
  - sample_out = s0 + (product >>> FRACWIDTH), arithmetic shift, i.e. floor.
  - Result truncated to WIDTH bits; it cannot overflow because it lies between s0 and s1.
  - sample_valid = 1 for this cycle only.
- Latency and rate:
  - Tick to sample_valid is 5 cycles.
  - Next tick can be accepted at T+6, so the maximum rate is 1 tick per 6 cycles.
- sample_tick while busy:
  - The tick is ignored and overrun pulses the same cycle.
  - The in-flight sample and phase are unaffected.
- phase_rst:
  - Phase <= 0 at the next edge, in any state; the in-flight sample completes with its latched idx/frac.
  - phase_rst together with an accepted tick: the sample uses phase 0, and phase becomes tune_word.
- tune_word = 0: repeated ticks return the same sample.

Decomposition:
- Package synth_pkg holds:
  - osc_state_t enum (IDLE, RD0, RD1, RD2, CALC, OUT);
  - sample_t (logic signed [WIDTH-1:0]);
  - default width constants.
- One sub-module, lerp_unit: registered multiply plus combinational add/shift; inputs s0, s1, frac, en; output result.
- Sequencer and phase accumulator stay in wavetable_osc.

Test Plan:
- All tests connect the ROM model loaded with mem[i] = i*16 (so mem[4095] = 0xFFF0 = -16).
- Reset: hold Reset=0 for 3 cycles, then release -> all outputs 0, busy=0, rom_addr=0.
- Integer step:
  - Stimulus: tune_word=0x00100000, four ticks spaced 8 cycles apart.
  - Required: sample_out = 0, 16, 32, 48; each sample_valid exactly 5 cycles after its tick; rom_addr shows idx then idx+1.
- Half-step interpolation: tune_word=0x00080000, three ticks -> samples 0, 8, 16.
- Table wrap:
  - Stimulus: pulse phase_rst; tick with tune_word=0xFFF80000; second tick.
  - Required: second sample reads idx 4095 then 0, giving -16 + ((16*128)>>8) = -8 (0xFFF8).
- Overrun: tick at T, second tick at T+2 -> overrun pulse at T+2, only one sample_valid, phase advanced once.
- Mid-operation events:
  - Reset=0 at T+3 -> no sample_valid; state IDLE next cycle.
  - phase_rst during RD1 -> current sample unchanged; next sample uses idx 0 (value 0).
